// File: rtl/stage_handshake_buffer_if.sv
// ============================================================================
// Module   : stage_handshake_buffer_if
// Brief    : One valid/ready link between two pipeline stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stage_handshake_buffer_if #(
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

`default_nettype wire

// File: rtl/stage_handshake_buffer.sv
// ============================================================================
// Module   : stage_handshake_buffer
// Brief    : DEPTH-entry in-order valid/ready stage buffer with optional
//            empty bypass and redirect flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage_handshake_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int BYPASS = 0
) (
   input  wire logic                   i_clock,
   input  wire logic                   i_reset,
   stage_handshake_buffer_if.slave     up,
   stage_handshake_buffer_if.master    dn,
   input  wire logic                   i_flush,
   output logic [$clog2(DEPTH):0]      o_count,
   output logic                        o_empty,
   output logic                        o_full
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_byp_sel;
   logic w_bypass_fire;
   logic w_push;
   logic w_pop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_CNT_MAX);

   generate
      if (BYPASS != 0) begin : g_bypass
         assign w_byp_sel = w_empty;
      end else begin : g_registered
         assign w_byp_sel = 1'b0;
      end
   endgenerate

   // Ready is built from registered occupancy only, so no ready path crosses stages.
   assign up.ready = ~w_full & ~i_reset;

   assign w_bypass_fire = w_byp_sel & ~i_flush & up.valid & dn.ready;
   assign w_push        = up.valid & up.ready & ~i_flush & ~w_bypass_fire;
   assign w_pop         = ~w_empty & dn.ready & ~i_flush;

   assign dn.valid = ~i_flush & (~w_empty | (w_byp_sel & up.valid));
   assign dn.data  = w_byp_sel ? up.data : r_mem[r_rd_ptr];

   assign o_count = r_count;
   assign o_empty = w_empty;
   assign o_full  = w_full;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_ONE;
         end
      end
   end

   // Payload storage needs no reset; entries are only read once counted valid.
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= up.data;
      end
   end

endmodule

`default_nettype wire
